// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, operand-select codes and default width for the GCD job scheduler.
package gcd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, STORE, RESP} state_t;
  localparam logic SEL_IN = 1'b1;
  localparam logic SEL_SUB = 1'b0;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer moves to the other requester when a job completes.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_owner,
  output logic       gnt_any,
  output logic       gnt_idx
);
  logic ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (done) ptr <= ~done_owner;
  always_comb begin
    gnt_any = |req;
    gnt_idx = &req ? ptr : req[1];
  end
endmodule

// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler: arbitrates two requesters onto one subtractive-GCD datapath and returns results.
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_ITER = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy,
  output logic             x_ld,
  output logic             y_ld,
  output logic             x_sel,
  output logic             y_sel,
  output logic             d_o_ld,
  output logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] d_o,
  input  logic             x_neq_y,
  input  logic             x_lt_y
);
  localparam int CW = $clog2(MAX_ITER + 1);
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, win_a, win_b;
  logic [CW-1:0] cnt;
  logic owner, err_q, gnt_any, gnt_idx, grant, step, accept, at_max, zero;

  rr_arbiter2 u_arb (
    .clk(clk),
    .reset(reset),
    .req({req1_valid, req0_valid}),
    .done(accept),
    .done_owner(owner),
    .gnt_any(gnt_any),
    .gnt_idx(gnt_idx)
  );

  always_comb begin
    win_a = gnt_idx ? req1_a : req0_a;
    win_b = gnt_idx ? req1_b : req0_b;
    zero = win_a == '0 || win_b == '0;
    at_max = cnt == CW'(MAX_ITER);
    accept = state == RESP && (owner ? resp1_ready : resp0_ready);
    grant = state == IDLE && gnt_any;
    // a timed-out step issues no strobe; the job leaves RUN on that edge
    step = state == RUN && x_neq_y && !at_max;
    req0_ready = grant && !gnt_idx;
    req1_ready = grant && gnt_idx;
    x_ld = state == LOAD || (step && !x_lt_y);
    y_ld = state == LOAD || (step && x_lt_y);
    x_sel = state == LOAD ? SEL_IN : SEL_SUB;
    y_sel = state == LOAD ? SEL_IN : SEL_SUB;
    d_o_ld = state == STORE;
    busy = state != IDLE;
    resp0_valid = state == RESP && !owner;
    resp1_valid = state == RESP && owner;
    resp_err = state == RESP && err_q;
    resp_data = (state == RESP && !err_q) ? d_o : '0;
    x_i = a_q;
    y_i = b_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      owner <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          a_q <= win_a;
          b_q <= win_b;
          owner <= gnt_idx;
          err_q <= zero;
          state <= zero ? RESP : LOAD;
        end
        LOAD: begin
          cnt <= '0;
          state <= RUN;
        end
        RUN: if (!x_neq_y) state <= STORE;
          else if (at_max) begin
            err_q <= 1'b1;
            state <= RESP;
          end else cnt <= cnt + 1'b1;
        STORE: state <= RESP;
        RESP: if (accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gcd_job_scheduler.sv
// tb_gcd_job_scheduler: directed jobs against a behavioural datapath model with hand-computed results.
module tb_gcd_job_scheduler;
  logic clk = 1'b0, reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, resp_data, x_i, y_i, d_o;
  logic resp0_valid, resp0_ready, resp1_valid, resp1_ready, resp_err, busy;
  logic x_ld, y_ld, x_sel, y_sel, d_o_ld, x_neq_y, x_lt_y;
  logic [3:0] dx, dy, dd;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  gcd_job_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .x_ld(x_ld), .y_ld(y_ld), .x_sel(x_sel), .y_sel(y_sel), .d_o_ld(d_o_ld),
    .x_i(x_i), .y_i(y_i), .d_o(d_o), .x_neq_y(x_neq_y), .x_lt_y(x_lt_y)
  );

  // behavioural model of the shared datapath
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dx <= '0;
      dy <= '0;
      dd <= '0;
    end else begin
      if (x_ld) dx <= x_sel ? x_i : dx - dy;
      if (y_ld) dy <= y_sel ? y_i : dy - dx;
      if (d_o_ld) dd <= dx;
    end
  assign x_neq_y = dx != dy;
  assign x_lt_y = dx < dy;
  assign d_o = dd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, busy,
            x_ld, y_ld, x_sel, y_sel, d_o_ld, resp_data, x_i, y_i};
  endfunction

  // called at posedge+1 in IDLE with the job's valid already driven
  task automatic serve(input string tag, input logic own, input int exp_d, input int exp_e,
                       input int exp_lat, input int exp_str, input int hold, input logic drop);
    int lat = 0, str = 0;
    logic oth = 1'b0;
    #1;
    chk({tag, "_gnt"}, 32'(own ? req1_ready : req0_ready), 1);
    chk({tag, "_gnt_other"}, 32'(own ? req0_ready : req1_ready), 0);
    while (!(own ? resp1_valid : resp0_valid) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (drop) begin
        if (own) req1_valid = 1'b0;
        else req0_valid = 1'b0;
      end
      if (x_ld | y_ld | d_o_ld) str++;
      if (req0_ready | req1_ready | (own ? resp0_valid : resp1_valid)) oth = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_strobes"}, 32'(str), 32'(exp_str));
    chk({tag, "_data"}, 32'(resp_data), 32'(exp_d));
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_e));
    chk({tag, "_stray"}, 32'(oth), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold"}, 32'({resp0_valid | resp1_valid, busy, req0_ready | req1_ready, resp_err, resp_data}),
          32'({2'b11, 1'b0, 1'(exp_e), 4'(exp_d)}));
    end
    if (own) resp1_ready = 1'b1;
    else resp0_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'({resp0_valid, resp1_valid, busy}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b} = '0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'(outs()), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_outs", 32'(outs()), 0);

    req0_a = 12; req0_b = 8; req0_valid = 1'b1;
    serve("j12_8", 1'b0, 4, 0, 6, 4, 0, 1'b1);
    req0_a = 7; req0_b = 7; req0_valid = 1'b1;
    serve("j7_7", 1'b0, 7, 0, 4, 2, 0, 1'b1);
    req1_a = 0; req1_b = 5; req1_valid = 1'b1;
    serve("zero", 1'b1, 0, 1, 1, 0, 0, 1'b1);

    resp0_ready = 1'b0;
    req0_a = 15; req0_b = 1; req0_valid = 1'b1;
    req1_a = 3; req1_b = 3; req1_valid = 1'b1;
    serve("hold", 1'b0, 1, 0, 18, 16, 5, 1'b1);
    serve("after_hold", 1'b1, 3, 0, 4, 2, 0, 1'b1);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_a = 9; req0_b = 6; req1_a = 10; req1_b = 4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve("rr0", 1'b0, 3, 0, 6, 4, 0, 1'b0);
    serve("rr1", 1'b1, 2, 0, 7, 5, 0, 1'b0);
    serve("rr2", 1'b0, 3, 0, 6, 4, 0, 1'b0);
    serve("rr3", 1'b1, 2, 0, 7, 5, 0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    req0_a = 13; req0_b = 2; req0_valid = 1'b1;
    #1;
    chk("mid_gnt", 32'(req0_ready), 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", 32'({busy, x_ld}), 3);
    reset = 1'b1;
    #1;
    chk("mid_rst", 32'(outs()), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_a = 6; req0_b = 4; req0_valid = 1'b1;
    serve("after_rst", 1'b0, 2, 0, 6, 4, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
